// File: rtl/ex_operand_stage.sv
// EX pipeline register with operand forwarding ahead of the ALU.
// Resolves EX/MEM and MEM/WB hazards combinationally; inserts one bubble on load-use.
module ex_operand_stage #(
  parameter int                 DATA_W = 64,
  parameter int                 CTRL_W = 5,
  parameter int                 REG_W  = 5,
  parameter int                 ZREG   = 31,
  parameter logic [CTRL_W-1:0]  OPNULL = '0
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic [CTRL_W-1:0] iControl,
  input  logic [REG_W-1:0]  iRs1,
  input  logic [REG_W-1:0]  iRs2,
  input  logic [REG_W-1:0]  iRd,
  input  logic [DATA_W-1:0] iRs1Data,
  input  logic [DATA_W-1:0] iRs2Data,
  input  logic [DATA_W-1:0] iImm,
  input  logic              iUseImm,
  input  logic              iRegWrite,
  input  logic              iMemRead,
  input  logic [REG_W-1:0]  iExMemRd,
  input  logic              iExMemRegWrite,
  input  logic [DATA_W-1:0] iExMemResult,
  input  logic [REG_W-1:0]  iMemWbRd,
  input  logic              iMemWbRegWrite,
  input  logic [DATA_W-1:0] iMemWbData,
  input  logic              iStall,
  input  logic              iFlush,
  output logic              oValid,
  output logic [CTRL_W-1:0] oControl,
  output logic [DATA_W-1:0] oA,
  output logic [DATA_W-1:0] oB,
  output logic [DATA_W-1:0] oStoreData,
  output logic [REG_W-1:0]  oRd,
  output logic              oRegWrite,
  output logic              oMemRead
);

  localparam logic [REG_W-1:0] ZTAG = REG_W'(ZREG);

  logic              valid_q,    valid_d;
  logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
  logic [REG_W-1:0]  rs1_q,      rs1_d;
  logic [REG_W-1:0]  rs2_q,      rs2_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic              use_imm_q,  use_imm_d;
  logic [REG_W-1:0]  rd_q,       rd_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q,  mem_read_d;

  logic [DATA_W-1:0] fwd_rs1;
  logic [DATA_W-1:0] fwd_rs2;
  logic              hz;

  function automatic logic [DATA_W-1:0] fwd(input logic [REG_W-1:0]  tag,
                                             input logic [DATA_W-1:0] stored);
    if (tag == ZTAG)                              return '0;
    else if (iExMemRegWrite && iExMemRd == tag)   return iExMemResult;
    else if (iMemWbRegWrite && iMemWbRd == tag)   return iMemWbData;
    else                                          return stored;
  endfunction

  assign fwd_rs1 = fwd(rs1_q, rs1_data_q);
  assign fwd_rs2 = fwd(rs2_q, rs2_data_q);

  assign hz = valid_q & mem_read_q & iValid & (rd_q != ZTAG) &
              ((iRs1 == rd_q) | (iRs2 == rd_q));

  assign oReady     = ~iStall & ~iFlush & ~hz;
  assign oValid     = valid_q;
  assign oControl   = valid_q ? ctrl_q : OPNULL;
  assign oA         = fwd_rs1;
  assign oB         = use_imm_q ? imm_q : fwd_rs2;
  assign oStoreData = fwd_rs2;
  assign oRd        = rd_q;
  assign oRegWrite  = valid_q & reg_write_q;
  assign oMemRead   = valid_q & mem_read_q;

  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (iFlush || (!iStall && (hz || !iValid))) begin
      valid_d     = 1'b0;
      ctrl_d      = OPNULL;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end else if (iStall) begin
      // Refresh held operands so writebacks retiring during the stall survive it.
      rs1_data_d = fwd_rs1;
      rs2_data_d = fwd_rs2;
    end else begin
      valid_d     = 1'b1;
      ctrl_d      = iControl;
      rs1_d       = iRs1;
      rs2_d       = iRs2;
      rs1_data_d  = iRs1Data;
      rs2_data_d  = iRs2Data;
      imm_d       = iImm;
      use_imm_d   = iUseImm;
      rd_d        = iRd;
      reg_write_d = iRegWrite;
      mem_read_d  = iMemRead;
    end
  end

  // Source tags reset to the zero register so cleared operands read as 0.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      valid_q     <= 1'b0;
      ctrl_q      <= OPNULL;
      rs1_q       <= ZTAG;
      rs2_q       <= ZTAG;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed hazard scenarios then random traffic
// checked against an instruction-level model of the EX slot.
module tb_ex_operand_stage;

  localparam logic [4:0] OPNULL = 5'd0;
  localparam logic [4:0] OPADD  = 5'd2;
  localparam logic [4:0] OPLDUR = 5'd9;
  localparam logic [4:0] ZR     = 5'd31;

  logic        iCLK = 1'b0;
  logic        iRST_n, iValid, oReady;
  logic [4:0]  iControl, iRs1, iRs2, iRd;
  logic [63:0] iRs1Data, iRs2Data, iImm;
  logic        iUseImm, iRegWrite, iMemRead;
  logic [4:0]  iExMemRd, iMemWbRd;
  logic        iExMemRegWrite, iMemWbRegWrite;
  logic [63:0] iExMemResult, iMemWbData;
  logic        iStall, iFlush;
  logic        oValid, oRegWrite, oMemRead;
  logic [4:0]  oControl, oRd;
  logic [63:0] oA, oB, oStoreData;

  always #5 iCLK = ~iCLK;

  ex_operand_stage dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iValid(iValid), .oReady(oReady),
    .iControl(iControl), .iRs1(iRs1), .iRs2(iRs2), .iRd(iRd),
    .iRs1Data(iRs1Data), .iRs2Data(iRs2Data), .iImm(iImm),
    .iUseImm(iUseImm), .iRegWrite(iRegWrite), .iMemRead(iMemRead),
    .iExMemRd(iExMemRd), .iExMemRegWrite(iExMemRegWrite), .iExMemResult(iExMemResult),
    .iMemWbRd(iMemWbRd), .iMemWbRegWrite(iMemWbRegWrite), .iMemWbData(iMemWbData),
    .iStall(iStall), .iFlush(iFlush),
    .oValid(oValid), .oControl(oControl), .oA(oA), .oB(oB), .oStoreData(oStoreData),
    .oRd(oRd), .oRegWrite(oRegWrite), .oMemRead(oMemRead)
  );

  // Instruction currently occupying EX in the reference model.
  typedef struct {
    bit          v;
    logic [4:0]  ctrl, rs1, rs2, rd;
    logic [63:0] d1, d2, imm;
    bit          ui, rw, mr;
  } ins_t;

  typedef struct {
    bit          full;
    bit          v, rdy;
    logic [4:0]  ctrl, rd;
    logic [63:0] a, b, sd;
    bit          rw, mr;
  } exp_t;

  ins_t ex;
  exp_t sb[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;

  // Architectural value of a register as seen by EX: youngest in-flight writer wins.
  function automatic logic [63:0] resolve(input logic [4:0] tag, input logic [63:0] stored);
    logic [4:0]  wtag[$];
    logic [63:0] wval[$];
    if (tag == ZR) return 64'd0;
    if (iExMemRegWrite) begin wtag.push_back(iExMemRd); wval.push_back(iExMemResult); end
    if (iMemWbRegWrite) begin wtag.push_back(iMemWbRd); wval.push_back(iMemWbData); end
    foreach (wtag[k]) if (wtag[k] == tag) return wval[k];
    return stored;
  endfunction

  function automatic logic [4:0] rnd_reg();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? ZR : 5'(r);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  // Push this cycle's expectation, then advance the model across one clock edge.
  task automatic step();
    exp_t e;
    ins_t nx;
    bit   hzm;
    if (!iRST_n) ex = '{default: 0};
    hzm = ex.v && ex.mr && iValid && (ex.rd != ZR) && (iRs1 == ex.rd || iRs2 == ex.rd);
    e.full = !iRST_n;
    e.v    = ex.v;
    e.rdy  = !iStall && !iFlush && !hzm;
    e.ctrl = ex.v ? ex.ctrl : OPNULL;
    e.sd   = e.full ? 64'd0 : resolve(ex.rs2, ex.d2);
    e.a    = e.full ? 64'd0 : resolve(ex.rs1, ex.d1);
    e.b    = ex.ui ? ex.imm : e.sd;
    e.rd   = ex.rd;
    e.rw   = ex.v && ex.rw;
    e.mr   = ex.v && ex.mr;
    sb.push_back(e);
    mon_en = 1'b1;

    nx = ex;
    if (!iRST_n) nx = '{default: 0};
    else if (iFlush || (!iStall && (hzm || !iValid))) begin
      nx.v = 0; nx.rw = 0; nx.mr = 0;
    end else if (iStall) begin
      nx.d1 = resolve(ex.rs1, ex.d1);
      nx.d2 = resolve(ex.rs2, ex.d2);
    end else begin
      nx = '{v: 1, ctrl: iControl, rs1: iRs1, rs2: iRs2, rd: iRd, d1: iRs1Data,
             d2: iRs2Data, imm: iImm, ui: iUseImm, rw: iRegWrite, mr: iMemRead};
    end
    @(posedge iCLK);
    ex = nx;
    cyc++;
    #1;
  endtask

  always @(negedge iCLK) begin
    if (mon_en) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty cycle=%0d actual=output_present required=expectation", cyc);
      end else begin
        me = sb.pop_front();
        chk("valid",    64'(oValid),    64'(me.v));
        chk("ready",    64'(oReady),    64'(me.rdy));
        chk("control",  64'(oControl),  64'(me.ctrl));
        chk("regwrite", 64'(oRegWrite), 64'(me.rw));
        chk("memread",  64'(oMemRead),  64'(me.mr));
        if (me.v || me.full) begin
          chk("opA",       oA,         me.a);
          chk("opB",       oB,         me.b);
          chk("storedata", oStoreData, me.sd);
          chk("rd",        64'(oRd),   64'(me.rd));
        end
        if (oValid)
          $display("txn cycle=%0d ctrl=%0d A=%h B=%h SD=%h rd=%0d rw=%0b mr=%0b",
                   cyc, oControl, oA, oB, oStoreData, oRd, oRegWrite, oMemRead);
      end
    end
  end

  task automatic idle();
    iValid = 0; iStall = 0; iFlush = 0;
  endtask

  task automatic clr_fwd();
    iExMemRegWrite = 0; iMemWbRegWrite = 0; iExMemRd = 0; iMemWbRd = 0;
    iExMemResult = 0; iMemWbData = 0;
  endtask

  task automatic issue(input logic [4:0] c, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                       input logic [63:0] imm, input bit ui, input bit rw, input bit mr);
    iValid = 1; iControl = c; iRs1 = r1; iRs2 = r2; iRd = rd;
    iRs1Data = d1; iRs2Data = d2; iImm = imm; iUseImm = ui; iRegWrite = rw; iMemRead = mr;
  endtask

  initial begin
    iRST_n = 0;
    idle();
    clr_fwd();
    issue(OPNULL, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    iValid = 0;
    @(posedge iCLK); #1;
    repeat (2) step();
    iRST_n = 1;
    step();

    // Plain ADD, no forwarding
    issue(OPADD, 1, 2, 3, 64'd5, 64'd7, 64'd0, 0, 1, 0); step();
    idle(); step(); step();

    // Forwarding priority on rs1=3, held in EX by a stall
    issue(OPADD, 3, 2, 5, 64'h5, 64'h7, 64'd0, 0, 1, 0); step();
    idle(); iStall = 1;
    iExMemRd = 3; iExMemResult = 64'h11; iExMemRegWrite = 1;
    iMemWbRd = 3; iMemWbData = 64'h22; iMemWbRegWrite = 1;
    step();
    iExMemRegWrite = 0; step();
    idle(); clr_fwd(); step();

    // Zero register is never forwarded
    issue(OPADD, ZR, 2, 5, 64'h77, 64'h7, 64'd0, 0, 1, 0); step();
    idle(); iExMemRd = ZR; iExMemRegWrite = 1; iExMemResult = 64'hdead; step();
    clr_fwd(); step();

    // Load-use: one bubble, then MEM/WB forwarding
    issue(OPLDUR, 1, ZR, 4, 64'h100, 64'd0, 64'd8, 1, 1, 1); step();
    issue(OPADD, 4, 2, 6, 64'h0bad, 64'd7, 64'd0, 0, 1, 0); step();
    step();
    idle(); iMemWbRd = 4; iMemWbRegWrite = 1; iMemWbData = 64'h4444; step();
    clr_fwd(); step();

    // Three-cycle stall with a WB retiring into held rs2
    issue(OPADD, 1, 5, 7, 64'd1, 64'h55, 64'd0, 0, 1, 0); step();
    issue(OPADD, 2, 3, 8, 64'd2, 64'd3, 64'd0, 0, 1, 0); iStall = 1; step();
    iMemWbRd = 5; iMemWbRegWrite = 1; iMemWbData = 64'h99; step();
    clr_fwd(); step();
    idle(); step(); step();

    // Flush beats stall and drops the incoming instruction
    issue(OPADD, 1, 2, 9, 64'd3, 64'd4, 64'd0, 0, 1, 0); step();
    issue(OPLDUR, 1, 2, 10, 64'd5, 64'd6, 64'd16, 1, 1, 1); iStall = 1; iFlush = 1; step();
    idle(); step();

    // Reset during a stall discards the held instruction
    issue(OPADD, 1, 2, 3, 64'h12, 64'h34, 64'd0, 0, 1, 0); step();
    idle(); iStall = 1; iRST_n = 0; step(); step();
    iRST_n = 1; iStall = 0; step();
    issue(OPADD, 1, 2, 3, 64'd5, 64'd7, 64'd0, 0, 1, 0); step();
    idle(); step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      iRST_n         = ($urandom_range(0, 199) != 0);
      iValid         = ($urandom_range(0, 9) < 7);
      iControl       = 5'($urandom_range(1, 31));
      iRs1           = rnd_reg();
      iRs2           = rnd_reg();
      iRd            = rnd_reg();
      iRs1Data       = {$urandom, $urandom};
      iRs2Data       = {$urandom, $urandom};
      iImm           = {$urandom, $urandom};
      iUseImm        = ($urandom_range(0, 1) == 1);
      iRegWrite      = ($urandom_range(0, 3) != 0);
      iMemRead       = ($urandom_range(0, 2) == 0);
      iExMemRd       = rnd_reg();
      iExMemRegWrite = ($urandom_range(0, 1) == 1);
      iExMemResult   = {$urandom, $urandom};
      iMemWbRd       = rnd_reg();
      iMemWbRegWrite = ($urandom_range(0, 1) == 1);
      iMemWbData     = {$urandom, $urandom};
      iStall         = ($urandom_range(0, 4) == 0);
      iFlush         = ($urandom_range(0, 19) == 0);
      step();
    end

    iRST_n = 1;
    idle();
    clr_fwd();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
